// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requesting datapath and serial_adder_ctrl.
// The sub select exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         c_in;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         done;

  modport master (
    output start, x, y, c_in,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  ready, sum, c_out, done
  );

  modport slave (
    input  start, x, y, c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output ready, sum, c_out, done
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Nibble-serial adder: one shared 4-bit adder, LSB nibble per clock, carry kept in cr.
// Optional subtract (x - y) enabled by defining SERIAL_ADDER_SUB_EN.
module four_bit_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
endmodule

module serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  xr_q, xr_d, yr_q, yr_d;
  logic [W-1:0]  acc_q, acc_d, sum_q, sum_d;
  logic          cr_q, cr_d, cout_q, cout_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          inv;
  logic [3:0]    a_nib, b_nib, s_nib;
  logic          co;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q, sub_d;
  assign inv = sub_q;
`else
  assign inv = 1'b0;
`endif

  assign a_nib = xr_q[4*idx_q +: 4];
  assign b_nib = yr_q[4*idx_q +: 4] ^ {4{inv}};

  four_bit_adder u_add (
    .a_i (a_nib),
    .b_i (b_nib),
    .c_i (cr_q),
    .s_o (s_nib),
    .c_o (co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cr_q    <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cr_q    <= cr_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cr_d    = cr_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
`ifdef SERIAL_ADDER_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          xr_d    = bus.x;
          yr_d    = bus.y;
          cr_d    = bus.c_in;
          idx_d   = '0;
          acc_d   = '0;
          state_d = RUN;
`ifdef SERIAL_ADDER_SUB_EN
          // Two's complement subtract: inverted y plus a forced carry-in of 1.
          sub_d   = bus.sub;
          if (bus.sub) cr_d = 1'b1;
`endif
        end
      end
      RUN: begin
        acc_d[4*idx_q +: 4] = s_nib;
        cr_d  = co;
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST) begin
          sum_d   = acc_d;
          cout_d  = co;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = cout_q;
endmodule
